// File: rtl/text_overlay_engine_pkg.sv
// Shared constants, font address layout and width helper for the text overlay engine.
package text_pkg;

  localparam int         CHAR_W     = 8;
  localparam int         CHAR_H     = 16;
  localparam int         CHAR_BITS  = 7;
  localparam int         FONT_AW    = 11;
  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic [6:0] CHAR_NULL  = 7'h00;

  typedef struct packed {
    logic [CHAR_BITS-1:0] chr;
    logic [3:0]           row;
  } font_addr_t;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_char_ram.sv
// One character plane: single write port, registered read port, read-before-write on collision.
module text_char_ram
  import text_pkg::*;
#(
  parameter int DEPTH = 2400,
  parameter int AW    = 12
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [CHAR_BITS-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [CHAR_BITS-1:0] o_rdata
);

  logic [CHAR_BITS-1:0] r_mem [DEPTH];
  logic [CHAR_BITS-1:0] r_rdata;

  // NOTE: the array itself is never reset so it maps onto block RAM; its
  // space-filled contents come from the configuration image.
  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // NOTE: non-blocking assignment makes the read sample the array before a
  // same-edge write lands, so a colliding read returns the old character.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/text_overlay_engine.sv
// Multi-layer text overlay: N character planes arbitrated by priority and
// transparency onto one shared font ROM port, fixed latency 3+FONT_LAT.
module text_overlay_engine
  import text_pkg::*;
#(
  parameter  int N_LAYERS  = 2,
  parameter  int COLS      = 80,
  parameter  int ROWS      = 30,
  parameter  int FONT_LAT  = 1,
  parameter  int BLINK_DIV = 5,
  localparam int LW        = clog2_min1(N_LAYERS),
  localparam int AW        = $clog2(COLS * ROWS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [10:0]          H_counter,
  input  logic [9:0]           V_counter,
  input  logic                 wr_en,
  input  logic [LW-1:0]        wr_layer,
  input  logic [AW-1:0]        wr_addr,
  input  logic [6:0]           wr_char,
  input  logic [N_LAYERS-1:0]  layer_en,
  input  logic [N_LAYERS-1:0]  blink_en,
  output logic [FONT_AW-1:0]   font_addr,
  input  logic [7:0]           font_data,
  output logic                 output_bit,
  output logic [LW-1:0]        layer_hit,
  output logic                 pixel_valid
);

  localparam int DEPTH = COLS * ROWS;

  typedef struct packed {
    logic [2:0]    bit_sel;
    logic          in_region;
    logic          any_hit;
    logic [LW-1:0] layer;
  } side_t;

  logic                 w_in_region;
  logic [AW-1:0]        w_cell_idx;
  logic                 w_wr_ok;
  logic                 w_blink_phase;
  logic [CHAR_BITS-1:0] w_rd_char [N_LAYERS];
  logic [N_LAYERS-1:0]  w_opaque;
  logic                 w_any_hit;
  logic [LW-1:0]        w_win_layer;
  logic [CHAR_BITS-1:0] w_win_char;
  side_t                w_late;

  logic [AW-1:0]        r_s0_idx;
  logic [3:0]           r_s0_row, r_s1_row;
  logic [2:0]           r_s0_bit, r_s1_bit;
  logic                 r_s0_in, r_s1_in;
  logic [BLINK_DIV-1:0] r_frame_cnt;
  font_addr_t           r_font_addr;
  side_t                r_side [FONT_LAT];
  logic                 r_output_bit;
  logic [LW-1:0]        r_layer_hit;
  logic                 r_pixel_valid;

  assign w_in_region = (32'(H_counter) < COLS * CHAR_W) && (32'(V_counter) < ROWS * CHAR_H);
  assign w_cell_idx  = AW'(32'(V_counter[9:4]) * COLS + 32'(H_counter[10:3]));
  assign w_wr_ok     = wr_en && (32'(wr_layer) < N_LAYERS) && (32'(wr_addr) < DEPTH);
  assign w_blink_phase = r_frame_cnt[BLINK_DIV-1];

  // Out-of-region positions read cell 0 so the RAM index never leaves its range.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_s0_idx    <= '0;
      r_s0_row    <= '0;
      r_s0_bit    <= '0;
      r_s0_in     <= 1'b0;
      r_s1_row    <= '0;
      r_s1_bit    <= '0;
      r_s1_in     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_s0_idx <= w_in_region ? w_cell_idx : '0;
      r_s0_row <= V_counter[3:0];
      r_s0_bit <= H_counter[2:0];
      r_s0_in  <= w_in_region;
      r_s1_row <= r_s0_row;
      r_s1_bit <= r_s0_bit;
      r_s1_in  <= r_s0_in;
      if (H_counter == '0 && V_counter == '0) begin
        r_frame_cnt <= r_frame_cnt + BLINK_DIV'(1);
      end
    end
  end

  for (genvar g = 0; g < N_LAYERS; g++) begin : g_layer
    text_char_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_ram (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_we    (w_wr_ok && (wr_layer == LW'(g))),
      .i_waddr (wr_addr),
      .i_wdata (wr_char),
      .i_raddr (r_s0_idx),
      .o_rdata (w_rd_char[g])
    );

    assign w_opaque[g] = layer_en[g]
                      && (w_rd_char[g] != CHAR_NULL)
                      && (w_rd_char[g] != CHAR_SPACE)
                      && !(blink_en[g] && w_blink_phase);
  end

  // Scan from the lowest priority upward so the lowest opaque index is the last writer.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_any_hit   = 1'b0;
    w_win_layer = '0;
    w_win_char  = CHAR_SPACE;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (w_opaque[i]) begin
        w_any_hit   = 1'b1;
        w_win_layer = LW'(i);
        w_win_char  = w_rd_char[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_font_addr <= '0;
      for (int i = 0; i < FONT_LAT; i++) begin
        r_side[i] <= '0;
      end
    end else begin
      r_font_addr <= font_addr_t'{chr: w_win_char, row: r_s1_row};
      r_side[0]   <= side_t'{bit_sel:   r_s1_bit,
                             in_region: r_s1_in,
                             any_hit:   w_any_hit,
                             layer:     w_win_layer};
      for (int i = 1; i < FONT_LAT; i++) begin
        r_side[i] <= r_side[i-1];
      end
    end
  end

  assign w_late = r_side[FONT_LAT-1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_output_bit  <= 1'b0;
      r_layer_hit   <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      r_output_bit  <= font_data[3'd7 - w_late.bit_sel] & w_late.in_region & w_late.any_hit;
      r_layer_hit   <= w_late.layer;
      r_pixel_valid <= w_late.in_region;
    end
  end

  assign font_addr   = r_font_addr;
  assign output_bit  = r_output_bit;
  assign layer_hit   = r_layer_hit;
  assign pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_text_overlay_engine.sv
// Directed bench for text_overlay_engine with a combinational font ROM model (FONT_LAT=1).
module tb_text_overlay_engine;
  import text_pkg::*;

  localparam int N_LAYERS  = 2;
  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int FONT_LAT  = 1;
  localparam int BLINK_DIV = 5;
  localparam int LW        = clog2_min1(N_LAYERS);
  localparam int AW        = $clog2(COLS * ROWS);
  localparam logic [10:0] H_PARK = 11'd1000;
  localparam logic [9:0]  V_PARK = 10'd1000;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [10:0]         H_counter;
  logic [9:0]          V_counter;
  logic                wr_en;
  logic [LW-1:0]       wr_layer;
  logic [AW-1:0]       wr_addr;
  logic [6:0]          wr_char;
  logic [N_LAYERS-1:0] layer_en;
  logic [N_LAYERS-1:0] blink_en;
  logic [10:0]         font_addr;
  logic [7:0]          font_data;
  logic                output_bit;
  logic [LW-1:0]       layer_hit;
  logic                pixel_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  text_overlay_engine #(
    .N_LAYERS  (N_LAYERS),
    .COLS      (COLS),
    .ROWS      (ROWS),
    .FONT_LAT  (FONT_LAT),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .H_counter   (H_counter),
    .V_counter   (V_counter),
    .wr_en       (wr_en),
    .wr_layer    (wr_layer),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .layer_en    (layer_en),
    .blink_en    (blink_en),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .output_bit  (output_bit),
    .layer_hit   (layer_hit),
    .pixel_valid (pixel_valid)
  );

  // Asymmetric glyph rows so a reversed bit order is visible.
  function automatic logic [7:0] rom_row(input logic [6:0] ch, input logic [3:0] row);
    return {ch[3:0], row} ^ {row, ch[6:3]} ^ 8'h35;
  endfunction

  assign font_data = rom_row(font_addr[10:4], font_addr[3:0]);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int layer, input int addr, input logic [6:0] ch);
    wr_en    = 1'b1;
    wr_layer = LW'(layer);
    wr_addr  = AW'(addr);
    wr_char  = ch;
    step();
    wr_en    = 1'b0;
  endtask

  task automatic pix(input int h, input int v, output logic [10:0] fa,
                     output logic ob, output logic [LW-1:0] lh, output logic pv);
    H_counter = 11'(h);
    V_counter = 10'(v);
    step();
    H_counter = H_PARK;
    V_counter = V_PARK;
    step();
    step();
    fa = font_addr;
    step();
    ob = output_bit;
    lh = layer_hit;
    pv = pixel_valid;
  endtask

  initial begin
    logic [10:0]   fa;
    logic          ob;
    logic [LW-1:0] lh;
    logic          pv;
    logic [7:0]    exp_row;

    RST_N     = 1'b0;
    H_counter = H_PARK;
    V_counter = V_PARK;
    wr_en     = 1'b0;
    wr_layer  = '0;
    wr_addr   = '0;
    wr_char   = '0;
    layer_en  = 2'b11;
    blink_en  = 2'b00;
    step();
    step();
    check("rst_output_bit",  32'(output_bit),  32'd0);
    check("rst_layer_hit",   32'(layer_hit),   32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_font_addr",   32'(font_addr),   32'd0);
    RST_N = 1'b1;

    for (int l = 0; l < N_LAYERS; l++) begin
      for (int a = 0; a < COLS * ROWS; a++) begin
        wr(l, a, 7'h20);
      end
    end

    // 'A' on layer 0, streamed across the eight pixels of cell 0
    wr(0, 0, 7'h41);
    exp_row = rom_row(7'h41, 4'd0);
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        H_counter = 11'(c);
        V_counter = 10'd0;
      end else begin
        H_counter = H_PARK;
        V_counter = V_PARK;
      end
      step();
      if (c >= 2 && c <= 9) check("a_font_addr", 32'(font_addr), 32'h410);
      if (c >= 3) begin
        check($sformatf("a_bit%0d", c - 3), 32'(output_bit), 32'(exp_row[7 - (c - 3)]));
        check("a_layer_hit", 32'(layer_hit),   32'd0);
        check("a_valid",     32'(pixel_valid), 32'd1);
      end
    end

    // Both planes blank: space address, no pixel even where the space glyph has ink
    pix(10, 0, fa, ob, lh, pv);
    check("blank_font_addr", 32'(fa), 32'h200);
    check("blank_bit",       32'(ob), 32'd0);
    check("blank_valid",     32'(pv), 32'd1);

    // Layer 1 shows through a transparent layer 0, then layer 0 takes over
    wr(1, 81, 7'h42);
    pix(8, 16, fa, ob, lh, pv);
    check("l1_font_addr", 32'(fa), 32'h420);
    check("l1_layer_hit", 32'(lh), 32'd1);
    check("l1_bit",       32'(ob), 32'(rom_row(7'h42, 4'd0) >> 7));
    wr(0, 81, 7'h43);
    pix(8, 16, fa, ob, lh, pv);
    check("l0_font_addr", 32'(fa), 32'h430);
    check("l0_layer_hit", 32'(lh), 32'd0);
    pix(11, 21, fa, ob, lh, pv);
    check("glyph_font_addr", 32'(fa), 32'h435);
    check("glyph_bit",       32'(ob), 32'(rom_row(7'h43, 4'd5) >> 4) & 32'd1);

    layer_en = 2'b10;
    pix(8, 16, fa, ob, lh, pv);
    check("dis_font_addr", 32'(fa), 32'h420);
    check("dis_layer_hit", 32'(lh), 32'd1);
    layer_en = 2'b11;

    // Outside the text region nothing is shown, even over stored characters
    wr(0, 80, 7'h58);
    wr(0, 2399, 7'h5A);
    pix(640, 0, fa, ob, lh, pv);
    check("oor_h_bit",   32'(ob), 32'd0);
    check("oor_h_valid", 32'(pv), 32'd0);
    pix(0, 480, fa, ob, lh, pv);
    check("oor_v_bit",   32'(ob), 32'd0);
    check("oor_v_valid", 32'(pv), 32'd0);
    pix(639, 479, fa, ob, lh, pv);
    check("corner_font_addr", 32'(fa), 32'h5AF);
    check("corner_valid",     32'(pv), 32'd1);
    check("corner_bit",       32'(ob), 32'(rom_row(7'h5A, 4'hF)) & 32'd1);

    // Write lands on the same edge that reads cell 5: old character is used
    wr(0, 5, 7'h44);
    H_counter = 11'd40;
    V_counter = 10'd0;
    step();
    H_counter = H_PARK;
    V_counter = V_PARK;
    wr_en     = 1'b1;
    wr_layer  = '0;
    wr_addr   = AW'(5);
    wr_char   = 7'h31;
    step();
    wr_en = 1'b0;
    step();
    check("coll_old_font_addr", 32'(font_addr), 32'h440);
    pix(40, 0, fa, ob, lh, pv);
    check("coll_new_font_addr", 32'(fa), 32'h310);

    wr(0, 2400, 7'h55);
    pix(2, 0, fa, ob, lh, pv);
    check("oob_wr_font_addr", 32'(fa), 32'h410);

    // Blink: restart the frame counter, 16 frames flips the phase, 16 more restores it
    RST_N = 1'b0;
    step();
    RST_N    = 1'b1;
    blink_en = 2'b01;
    for (int f = 0; f < 16; f++) begin
      H_counter = 11'd0;
      V_counter = 10'd0;
      step();
    end
    pix(2, 0, fa, ob, lh, pv);
    check("blink_off_font_addr", 32'(fa), 32'h200);
    check("blink_off_bit",       32'(ob), 32'd0);
    check("blink_off_valid",     32'(pv), 32'd1);
    for (int f = 0; f < 16; f++) begin
      H_counter = 11'd0;
      V_counter = 10'd0;
      step();
    end
    pix(2, 0, fa, ob, lh, pv);
    check("blink_on_font_addr", 32'(fa), 32'h410);
    check("blink_on_bit",       32'(ob), 32'(exp_row[5]));
    blink_en = 2'b00;

    // One-cycle reset in the middle of a run of visible pixels
    H_counter = 11'd2;
    V_counter = 10'd0;
    for (int c = 0; c < 5; c++) step();
    check("pre_rst_valid", 32'(pixel_valid), 32'd1);
    RST_N = 1'b0;
    step();
    check("mid_rst_output_bit",  32'(output_bit),  32'd0);
    check("mid_rst_layer_hit",   32'(layer_hit),   32'd0);
    check("mid_rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("mid_rst_font_addr",   32'(font_addr),   32'd0);
    RST_N = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("refill_valid_c%0d", c), 32'(pixel_valid), (c == 4) ? 32'd1 : 32'd0);
    end
    check("refill_bit",       32'(output_bit), 32'(exp_row[5]));
    check("refill_font_addr", 32'(font_addr),  32'h410);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/text_overlay_engine.md
Name: text_overlay_engine

Overview:
- Parametrised successor to the per-screen text controllers: draws N_LAYERS independent character planes onto the VGA raster through one shared font ROM port.
- Each layer has its own writable character buffer. A fixed-priority, transparency-aware arbiter replaces the old OR/add merge of character codes.
- Sits between the VGA timing generator (H_counter/V_counter) and the pixel colour mux. Drives a fixed-latency, pipelined pixel bit plus the index of the winning layer.

Parameters:
- N_LAYERS, 2, number of character planes; layer 0 has highest priority.
- COLS, 80, character columns per layer.
- ROWS, 30, character rows per layer.
- FONT_LAT, 1, font ROM read latency in cycles (addr registered to data valid).
- BLINK_DIV, 5, blink phase = frame_cnt[BLINK_DIV-1], so the phase toggles every 2^(BLINK_DIV-1) frames.

Ports:
- CLK  in  1  pixel clock.
- RST_N  in  1  synchronous active-low reset.
- H_counter  in  11  horizontal pixel position from timing generator.
- V_counter  in  10  vertical line position.
- wr_en  in  1  character buffer write strobe, accepted every cycle.
- wr_layer  in  LW=max(1,clog2(N_LAYERS))  target layer.
- wr_addr  in  AW=clog2(COLS*ROWS)  cell index = row*COLS+col.
- wr_char  in  7  ASCII code.
- layer_en  in  N_LAYERS  per-layer display enable.
- blink_en  in  N_LAYERS  per-layer blink enable.
- font_addr  out  11  {char[6:0], glyph_row[3:0]} to font ROM.
- font_data  in  8  glyph row; MSB is the leftmost pixel.
- output_bit  out  1  text pixel on/off.
- layer_hit  out  LW  layer that supplied the pixel.
- pixel_valid  out  1  output_bit corresponds to an in-region, pipeline-filled pixel.

Behaviour:
- Clock, reset: one clock (CLK); reset is synchronous and active-low (RST_N).
- Cell geometry: 8x16 cells. Text region is H_counter < COLS*8 and V_counter < ROWS*16.
  - col = H[10:3], row = V[9:4], glyph_row = V[3:0], bit_sel = H[2:0].
- Pipeline, counters sampled at cycle t:
  - S0 (t+1): cell index, glyph_row, bit_sel and in_region registered.
  - S1 (t+2): all N_LAYERS char RAMs return the registered read.
  - S2 (t+3): arbiter selects the winner and registers font_addr.
  - S3 (t+3+FONT_LAT): font_data sampled. output_bit = font_data[7-bit_sel] & in_region & any_hit.
- Total latency L = 3+FONT_LAT cycles, constant. Side-band (bit_sel, in_region, layer_hit) is delayed to match L exactly.
- Arbitration:
  - A layer is opaque when layer_en[i]=1, char not 0x00/0x20, and NOT (blink_en[i] & blink_phase).
  - Lowest opaque index wins. If none is opaque, font_addr = {0x20, glyph_row}, output_bit = 0, layer_hit = 0.
- Frame counter: BLINK_DIV bits. Increments on the cycle where sampled H_counter==0 && V_counter==0. Wraps naturally.
- Writes:
  - The selected layer RAM is written at the clock edge.
  - Same-cycle read and write to the same address returns OLD data; the new data is visible on the next read.
  - wr_layer >= N_LAYERS or wr_addr >= COLS*ROWS: write ignored.
- Reset:
  - All pipeline registers, frame counter and outputs go to 0 (output_bit=0, layer_hit=0, pixel_valid=0, font_addr=0).
  - Char RAM contents are NOT reset; they are initialised to 0x20 at configuration.
- Reset mid-frame: pixel_valid stays 0 for L cycles after RST_N rises. After that it equals the delayed in_region.
- Out of region: output_bit=0 and pixel_valid=0 regardless of buffer contents.

Decomposition:
- Shared package text_pkg:
  - CHAR_W=8, CHAR_H=16, CHAR_SPACE=7'h20, CHAR_NULL=7'h00, FONT_AW=11.
  - Typedef font_addr_t = {char, row}.
  - Function clog2_min1.
- Sub-module text_char_ram: 1 write/1 registered-read port, COLS*ROWS x 7. Instantiated per layer via generate.

Test Plan:
- Write 'A' (0x41) to layer0 addr 0; drive H=0..7, V=0 -> font_addr=0x410 at t+3. With ROM model, output_bit follows 'A' row0 bits MSB-first at t+4 (FONT_LAT=1); layer_hit=0; pixel_valid=1.
- Layer0 cell=0x20, layer1 cell=0x42 at addr 81 (row1,col1); H=8, V=16 -> font_addr=0x420, layer_hit=1. Then write layer0 cell=0x43 -> font_addr=0x430, layer_hit=0.
- blink_en=01, layer0 'A'; step 16 frames -> blink_phase=1, layer0 transparent, output_bit=0. After 16 more frames the glyph returns.
- H=640, V=0 and H=0, V=480 -> output_bit=0, pixel_valid=0 at t+L even with non-space chars stored.
- Write addr 5 with 0x31 in the same cycle S0 presents addr 5 -> old char used; next frame uses 0x31. Write with wr_addr=2400 -> no change.
- Assert RST_N=0 for 1 cycle mid-line -> next cycle all outputs 0; pixel_valid returns exactly L cycles after release; RAM contents unchanged.
